// File: rtl/ram_dx_be_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: FSM encoding and
// the legal range of the read latency parameter.
package ram_dx_be_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } state_t;

  localparam int unsigned CRdLatMin = 1;
  localparam int unsigned CRdLatMax = 2;

  function automatic bit rdLatLegal(input int unsigned lat);
    return (lat >= CRdLatMin) && (lat <= CRdLatMax);
  endfunction

endpackage

// File: rtl/ram_dx_be_core.sv
// Inferred dual-port byte-enable array with registered read addresses.
// Reads see the array after the same edge's writes, i.e. write-first on both ports.
module ram_dx_be_core #(
  parameter int unsigned CAddrLen = 11,
  parameter int unsigned CByteCnt = 4
) (
  input  logic                    AClkA,
  input  logic                    AClkAEn,
  input  logic [CAddrLen-1:0]     AAddrA,
  input  logic [CAddrLen-1:0]     AAddrB,
  input  logic [8*CByteCnt-1:0]   AMosiA,
  input  logic [8*CByteCnt-1:0]   AMosiB,
  input  logic [CByteCnt-1:0]     AWrEnA,
  input  logic [CByteCnt-1:0]     AWrEnB,
  output logic [8*CByteCnt-1:0]   ARdDataA,
  output logic [8*CByteCnt-1:0]   ARdDataB
);

  localparam int unsigned CDataLen = 8 * CByteCnt;
  localparam int unsigned CDepth   = 2 ** CAddrLen;

  logic [CDataLen-1:0] mem [CDepth];
  logic [CAddrLen-1:0] addrQA;
  logic [CAddrLen-1:0] addrQB;

  // Port A is written after port B so A owns any byte both ports enable.
  always_ff @(posedge AClkA) begin
    if (AClkAEn) begin
      for (int unsigned i = 0; i < CByteCnt; i++) begin
        if (AWrEnB[i]) mem[AAddrB][8*i +: 8] <= AMosiB[8*i +: 8];
        if (AWrEnA[i]) mem[AAddrA][8*i +: 8] <= AMosiA[8*i +: 8];
      end
      addrQA <= AAddrA;
      addrQB <= AAddrB;
    end
  end

  assign ARdDataA = mem[addrQA];
  assign ARdDataB = mem[addrQB];

endmodule

// File: rtl/ram_dx_be.sv
// Dual-port byte-enable RAM with optional post-reset clear sweep,
// 1- or 2-clock read latency and same-address write collision flag.
module ram_dx_be
  import ram_dx_be_pkg::*;
#(
  parameter int unsigned CAddrLen      = 11,
  parameter int unsigned CByteCnt      = 4,
  parameter int unsigned CRdLat        = 1,
  parameter int unsigned CClearOnReset = 1
) (
  input  logic                  AClkA,
  input  logic                  AResetAN,
  input  logic                  AClkAEn,
  input  logic [CAddrLen-1:0]   AAddrA,
  input  logic [CAddrLen-1:0]   AAddrB,
  input  logic [8*CByteCnt-1:0] AMosiA,
  input  logic [8*CByteCnt-1:0] AMosiB,
  input  logic [CByteCnt-1:0]   AWrEnA,
  input  logic [CByteCnt-1:0]   AWrEnB,
  input  logic                  ARdEnA,
  input  logic                  ARdEnB,
  output logic [8*CByteCnt-1:0] AMisoA,
  output logic [8*CByteCnt-1:0] AMisoB,
  output logic                  ABusy,
  output logic                  ACollision
);

  localparam int unsigned CDataLen = 8 * CByteCnt;
  localparam logic [CAddrLen-1:0] CLastAddr = '1;

  if (!rdLatLegal(CRdLat)) begin : gBadLat
    $error("ram_dx_be: CRdLat must be 1 or 2");
  end

  state_t              state;
  state_t              stateNxt;
  logic [CAddrLen-1:0] clrCnt;
  logic [CAddrLen-1:0] clrCntNxt;
  logic                ready;

  logic [CAddrLen-1:0] coreAddrA;
  logic [CDataLen-1:0] coreMosiA;
  logic [CByteCnt-1:0] coreWrEnA;
  logic [CByteCnt-1:0] coreWrEnB;
  logic [CDataLen-1:0] rawA;
  logic [CDataLen-1:0] rawB;

  logic rdV1A;
  logic rdV1B;
  logic collQ;

  always_ff @(posedge AClkA or negedge AResetAN) begin
    if (!AResetAN) begin
      if (CClearOnReset != 0) state <= StClear;
      else                    state <= StReady;
      clrCnt <= '0;
    end else if (AClkAEn) begin
      state  <= stateNxt;
      clrCnt <= clrCntNxt;
    end
  end

  // Counter parks on the last word when leaving CLEAR, never wrapping.
  always_comb begin
    stateNxt  = state;
    clrCntNxt = clrCnt;
    case (state)
      StClear: begin
        if (clrCnt == CLastAddr) stateNxt  = StReady;
        else                     clrCntNxt = clrCnt + 1'b1;
      end
      StReady: ;
      default: stateNxt = StReady;
    endcase
  end

  assign ready = (state == StReady);
  assign ABusy = (state == StClear);

  // During the sweep port A is borrowed to zero one word per clock.
  always_comb begin
    coreAddrA = AAddrA;
    coreMosiA = AMosiA;
    coreWrEnA = AWrEnA;
    coreWrEnB = AWrEnB;
    if (!ready) begin
      coreAddrA = clrCnt;
      coreMosiA = '0;
      coreWrEnA = '1;
      coreWrEnB = '0;
    end
  end

  ram_dx_be_core #(
    .CAddrLen (CAddrLen),
    .CByteCnt (CByteCnt)
  ) uCore (
    .AClkA    (AClkA),
    .AClkAEn  (AClkAEn),
    .AAddrA   (coreAddrA),
    .AAddrB   (AAddrB),
    .AMosiA   (coreMosiA),
    .AMosiB   (AMosiB),
    .AWrEnA   (coreWrEnA),
    .AWrEnB   (coreWrEnB),
    .ARdDataA (rawA),
    .ARdDataB (rawB)
  );

  always_ff @(posedge AClkA or negedge AResetAN) begin
    if (!AResetAN) begin
      rdV1A <= 1'b0;
      rdV1B <= 1'b0;
      collQ <= 1'b0;
    end else if (AClkAEn) begin
      rdV1A <= ready && ARdEnA;
      rdV1B <= ready && ARdEnB;
      collQ <= ready && ((AWrEnA & AWrEnB) != '0) && (AAddrA == AAddrB);
    end
  end

  assign ACollision = collQ;

  if (CRdLat == 2) begin : gLat2
    logic                rdV2A;
    logic                rdV2B;
    logic [CDataLen-1:0] misoQA;
    logic [CDataLen-1:0] misoQB;

    always_ff @(posedge AClkA or negedge AResetAN) begin
      if (!AResetAN) begin
        rdV2A  <= 1'b0;
        rdV2B  <= 1'b0;
        misoQA <= '0;
        misoQB <= '0;
      end else if (AClkAEn) begin
        rdV2A  <= rdV1A;
        rdV2B  <= rdV1B;
        misoQA <= rawA;
        misoQB <= rawB;
      end
    end

    assign AMisoA = rdV2A ? misoQA : '0;
    assign AMisoB = rdV2B ? misoQB : '0;
  end else begin : gLat1
    assign AMisoA = rdV1A ? rawA : '0;
    assign AMisoB = rdV1B ? rawB : '0;
  end

endmodule

// File: tb/tb_ram_dx_be.sv
// Bench for ram_dx_be: two DUTs (read latency 1 and 2) on shared stimulus,
// checked against a word-array reference model with a delayed result pipe.
module tb_ram_dx_be;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        en    = 1'b0;
  logic [3:0]  addrA = '0;
  logic [3:0]  addrB = '0;
  logic [31:0] mosiA = '0;
  logic [31:0] mosiB = '0;
  logic [3:0]  weA   = '0;
  logic [3:0]  weB   = '0;
  logic        rdA   = 1'b0;
  logic        rdB   = 1'b0;

  logic [31:0] misoA1, misoB1, misoA2, misoB2;
  logic        busy1, busy2, coll1, coll2;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  logic [31:0] mem [16];
  bit          mBusy;
  int unsigned mCnt;
  logic [31:0] e1A, e1B, e2A, e2B;
  bit          eColl;

  ram_dx_be #(.CAddrLen(4), .CByteCnt(4), .CRdLat(1), .CClearOnReset(1)) uDut1 (
    .AClkA(clk), .AResetAN(rstn), .AClkAEn(en),
    .AAddrA(addrA), .AAddrB(addrB), .AMosiA(mosiA), .AMosiB(mosiB),
    .AWrEnA(weA), .AWrEnB(weB), .ARdEnA(rdA), .ARdEnB(rdB),
    .AMisoA(misoA1), .AMisoB(misoB1), .ABusy(busy1), .ACollision(coll1)
  );

  ram_dx_be #(.CAddrLen(4), .CByteCnt(4), .CRdLat(2), .CClearOnReset(1)) uDut2 (
    .AClkA(clk), .AResetAN(rstn), .AClkAEn(en),
    .AAddrA(addrA), .AAddrB(addrB), .AMosiA(mosiA), .AMosiB(mosiB),
    .AWrEnA(weA), .AWrEnB(weB), .ARdEnA(rdA), .ARdEnB(rdB),
    .AMisoA(misoA2), .AMisoB(misoB2), .ABusy(busy2), .ACollision(coll2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byteMask(input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (we[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic modelReset();
    mBusy = 1'b1;
    mCnt  = 0;
    e1A = '0; e1B = '0; e2A = '0; e2B = '0;
    eColl = 1'b0;
  endtask

  task automatic modelStep();
    logic [31:0] mA, mB;
    e2A = e1A;
    e2B = e1B;
    if (mBusy) begin
      mem[mCnt] = '0;
      if (mCnt == 15) mBusy = 1'b0;
      else            mCnt++;
      e1A = '0; e1B = '0; eColl = 1'b0;
    end else begin
      mA = byteMask(weA);
      mB = byteMask(weB);
      mem[addrB] = (mem[addrB] & ~mB) | (mosiB & mB);
      mem[addrA] = (mem[addrA] & ~mA) | (mosiA & mA);
      eColl = (addrA == addrB) && ((weA & weB) != 4'h0);
      e1A = rdA ? mem[addrA] : 32'h0;
      e1B = rdB ? mem[addrB] : 32'h0;
    end
  endtask

  task automatic checkAll();
    chk("busy_l1",  busy1,  mBusy);
    chk("busy_l2",  busy2,  mBusy);
    chk("coll_l1",  coll1,  eColl);
    chk("coll_l2",  coll2,  eColl);
    chk("misoA_l1", misoA1, e1A);
    chk("misoB_l1", misoB1, e1B);
    chk("misoA_l2", misoA2, e2A);
    chk("misoB_l2", misoB2, e2B);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn && en) modelStep();
    #1;
    checkAll();
  endtask

  task automatic pulseReset();
    rstn = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    #2;
    rstn = 1'b1;
  endtask

  task automatic idle();
    en = 1'b1;
    weA = '0; weB = '0; rdA = 1'b0; rdB = 1'b0;
  endtask

  task automatic randIn();
    addrA = 4'($urandom_range(0, 15));
    addrB = ($urandom_range(0, 3) == 0) ? addrA : 4'($urandom_range(0, 15));
    mosiA = $urandom;
    mosiB = $urandom;
    weA   = 4'($urandom_range(0, 15));
    weB   = 4'($urandom_range(0, 15));
    rdA   = 1'($urandom_range(0, 1));
    rdB   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int busyCnt;
    bit wasBusy;

    #2;
    pulseReset();

    // Sweep with random ignored traffic and clock-enable gaps, up to address 8
    for (int i = 0; i < 100 && mCnt != 8; i++) begin
      randIn();
      en = ($urandom_range(0, 3) != 0);
      tick();
    end
    nTests++;
    if (mCnt != 8) begin
      nFail++;
      $error("FAIL sweep_reach8 observed=%0d expected=8", mCnt);
    end

    // Reset mid-sweep: the sweep must restart and last a full 16 enabled clocks
    pulseReset();
    busyCnt = 0;
    for (int i = 0; i < 200; i++) begin
      randIn();
      en = ($urandom_range(0, 3) != 0);
      wasBusy = busy1;
      tick();
      if (en && wasBusy) busyCnt++;
      if (busy1 === 1'b0) break;
    end
    chk("busy_len", busyCnt, 16);

    // Cleared array reads zero
    idle(); rdA = 1'b1; addrA = 4'd7;
    tick();
    chk("rd7_l1", misoA1, 32'h0);
    idle();
    tick();
    chk("rd7_l2", misoA2, 32'h0);

    // Full A write then byte-0 B write to the same word
    idle(); addrA = 4'd3; mosiA = 32'h11223344; weA = 4'hF;
    tick();
    idle(); addrB = 4'd3; mosiB = 32'hAABBCCDD; weB = 4'b0001;
    tick();
    idle(); addrA = 4'd3; rdA = 1'b1;
    tick();
    chk("merge_l1", misoA1, 32'h112233DD);
    idle();
    tick();
    chk("merge_l2", misoA2, 32'h112233DD);
    chk("merge_l1_idle", misoA1, 32'h0);

    // Overlapping dual write: A owns byte 1, B supplies byte 2
    idle(); addrA = 4'd5; addrB = 4'd5;
    mosiA = 32'h00005566; weA = 4'b0011;
    mosiB = 32'h00778800; weB = 4'b0110;
    tick();
    chk("coll_pulse", coll1, 1'b1);
    idle(); addrA = 4'd5; rdA = 1'b1;
    tick();
    chk("coll_drop", coll1, 1'b0);
    chk("coll_word", misoA1, 32'h00775566);

    // Cross-port write-first read
    idle(); addrA = 4'd9; mosiA = 32'hCAFEBABE; weA = 4'hF; addrB = 4'd9; rdB = 1'b1;
    tick();
    chk("xport_l1", misoB1, 32'hCAFEBABE);
    chk("xport_l2_early", misoB2, 32'h0);
    idle();
    tick();
    chk("xport_l2", misoB2, 32'hCAFEBABE);

    // Clock-enable freeze in the middle of a read
    idle(); addrA = 4'd3; rdA = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      randIn();
      en = 1'b0;
      tick();
      chk("freeze_l1", misoA1, 32'h112233DD);
      chk("freeze_l2", misoA2, 32'h0);
    end
    idle();
    tick();
    chk("resume_l2", misoA2, 32'h112233DD);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      randIn();
      en = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
